// File: rtl/sisc_wb_pkg.sv
// Shared constants for the SISC writeback path.
// Source indices, mux select encodings and counter width.
package sisc_wb_pkg;

  localparam int SRC_ALU = 0;
  localparam int SRC_MEM = 1;
  localparam int SRC_PC  = 2;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC  = 2'b10;

  localparam int WAIT_CNT_W = 16;

  typedef logic [2:0] src_vec_t;

  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// Three-way combinational picker.
// Priority starts at the given index, or at ALU in fixed mode.
module rr_pick3
  import sisc_wb_pkg::*;
(
  input  logic [2:0] elig,
  input  logic [1:0] start,
  input  logic       fixed,
  output logic [2:0] win,
  output logic       valid
);

  logic [1:0] first;

  always_comb begin
    first = fixed ? 2'd0 : start;
    win   = 3'b000;
    valid = |elig;
    unique case (first)
      2'd0: begin
        if (elig[SRC_ALU])      win = 3'b001;
        else if (elig[SRC_MEM]) win = 3'b010;
        else if (elig[SRC_PC])  win = 3'b100;
      end
      2'd1: begin
        if (elig[SRC_MEM])      win = 3'b010;
        else if (elig[SRC_PC])  win = 3'b100;
        else if (elig[SRC_ALU]) win = 3'b001;
      end
      default: begin
        if (elig[SRC_PC])       win = 3'b100;
        else if (elig[SRC_ALU]) win = 3'b001;
        else if (elig[SRC_MEM]) win = 3'b010;
      end
    endcase
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write port arbiter for ALU, MEM and PC writebacks.
// All outputs are registered; a source is masked during its own grant.
module rf_wb_arbiter
  import sisc_wb_pkg::*;
#(
  parameter bit RR_EN = 1'b1,
  parameter int AW    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            req,
  input  logic [AW-1:0]         waddr_alu,
  input  logic [AW-1:0]         waddr_mem,
  input  logic [AW-1:0]         waddr_pc,
  output logic [2:0]            gnt,
  output logic [1:0]            wb_sel,
  output logic                  rf_we,
  output logic [AW-1:0]         rf_waddr,
  output logic [WAIT_CNT_W-1:0] wait_cnt
);

  logic [1:0]    last;
  logic [2:0]    elig;
  logic [2:0]    win;
  logic          valid;
  logic          multi;
  logic          fixed_mode;
  logic [1:0]    sel_n;
  logic [1:0]    idx_n;
  logic [AW-1:0] addr_n;

  assign fixed_mode = ~RR_EN;
  assign elig  = req & ~gnt;
  assign multi = (elig[0] & elig[1]) |
                 (elig[0] & elig[2]) |
                 (elig[1] & elig[2]);

  rr_pick3 u_pick (
    .elig  (elig),
    .start (next_idx(last)),
    .fixed (fixed_mode),
    .win   (win),
    .valid (valid)
  );

  always_comb begin
    sel_n  = wb_sel;
    idx_n  = last;
    addr_n = rf_waddr;
    if (valid) begin
      unique case (1'b1)
        win[SRC_ALU]: begin
          sel_n  = WB_SEL_ALU;
          idx_n  = 2'd0;
          addr_n = waddr_alu;
        end
        win[SRC_MEM]: begin
          sel_n  = WB_SEL_MEM;
          idx_n  = 2'd1;
          addr_n = waddr_mem;
        end
        default: begin
          sel_n  = WB_SEL_PC;
          idx_n  = 2'd2;
          addr_n = waddr_pc;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt      <= 3'b000;
      wb_sel   <= WB_SEL_ALU;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      wait_cnt <= '0;
      last     <= 2'd2;
    end else begin
      gnt      <= win;
      rf_we    <= valid;
      wb_sel   <= sel_n;
      rf_waddr <= addr_n;
      last     <= idx_n;
      // saturate rather than wrap
      if (multi && wait_cnt != '1)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomised and directed bench for rf_wb_arbiter.
// Round-robin and fixed-priority instances run side by side.
module tb_rf_wb_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] req = 3'b000;
  logic [3:0] waddr_alu = 4'd0;
  logic [3:0] waddr_mem = 4'd0;
  logic [3:0] waddr_pc  = 4'd0;

  logic [2:0]  gnt_rr, gnt_fx;
  logic [1:0]  sel_rr, sel_fx;
  logic        we_rr, we_fx;
  logic [3:0]  wa_rr, wa_fx;
  logic [15:0] cnt_rr, cnt_fx;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.RR_EN(1'b1), .AW(4)) u_rr (
    .clk(clk), .rst(rst), .req(req),
    .waddr_alu(waddr_alu), .waddr_mem(waddr_mem),
    .waddr_pc(waddr_pc), .gnt(gnt_rr), .wb_sel(sel_rr),
    .rf_we(we_rr), .rf_waddr(wa_rr), .wait_cnt(cnt_rr)
  );

  rf_wb_arbiter #(.RR_EN(1'b0), .AW(4)) u_fx (
    .clk(clk), .rst(rst), .req(req),
    .waddr_alu(waddr_alu), .waddr_mem(waddr_mem),
    .waddr_pc(waddr_pc), .gnt(gnt_fx), .wb_sel(sel_fx),
    .rf_we(we_fx), .rf_waddr(wa_fx), .wait_cnt(cnt_fx)
  );

  typedef struct {
    logic [2:0] gnt;
    logic [1:0] sel;
    logic       we;
    logic [3:0] addr;
    int         cnt;
    int         last;
  } mstate_t;

  mstate_t m_rr, m_fx;
  bit model_ok = 0;

  function automatic mstate_t reset_state();
    mstate_t s;
    s.gnt = 0; s.sel = 0; s.we = 0;
    s.addr = 0; s.cnt = 0; s.last = 2;
    return s;
  endfunction

  function automatic mstate_t advance(
    mstate_t s, bit fixed, logic [2:0] r,
    logic [3:0] a0, logic [3:0] a1, logic [3:0] a2);
    mstate_t n = s;
    logic [2:0] e = r & ~s.gnt;
    logic [3:0] a[3];
    int w = -1;
    a[0] = a0; a[1] = a1; a[2] = a2;
    if ($countones(e) > 1 && s.cnt < 65535)
      n.cnt = s.cnt + 1;
    for (int k = 0; k < 3; k++) begin
      int i = fixed ? k : (s.last + 1 + k) % 3;
      if (w < 0 && e[i]) w = i;
    end
    if (w >= 0) begin
      n.gnt = 3'(1 << w);
      n.sel = 2'(w);
      n.addr = a[w];
      n.we = 1;
      n.last = w;
    end else begin
      n.gnt = 0;
      n.we = 0;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_rr <= reset_state();
      m_fx <= reset_state();
      model_ok <= 1;
    end else begin
      m_rr <= advance(m_rr, 0, req, waddr_alu, waddr_mem, waddr_pc);
      m_fx <= advance(m_fx, 1, req, waddr_alu, waddr_mem, waddr_pc);
    end
  end

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_ok) begin
      chk("rr_gnt", int'(gnt_rr), int'(m_rr.gnt));
      chk("rr_sel", int'(sel_rr), int'(m_rr.sel));
      chk("rr_we", int'(we_rr), int'(m_rr.we));
      chk("rr_addr", int'(wa_rr), int'(m_rr.addr));
      chk("rr_cnt", int'(cnt_rr), m_rr.cnt);
      chk("fx_gnt", int'(gnt_fx), int'(m_fx.gnt));
      chk("fx_sel", int'(sel_fx), int'(m_fx.sel));
      chk("fx_we", int'(we_fx), int'(m_fx.we));
      chk("fx_addr", int'(wa_fx), int'(m_fx.addr));
      chk("fx_cnt", int'(cnt_fx), m_fx.cnt);
      chk("sel_not3", int'(sel_rr == 2'b11), 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 3'b000;
    step();
    rst = 1'b0;
  endtask

  logic [2:0] exp_seq[6];

  initial begin
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_gnt", int'(gnt_rr), 0);
    chk("rst_we", int'(we_rr), 0);
    chk("rst_sel", int'(sel_rr), 0);
    chk("rst_addr", int'(wa_rr), 0);
    chk("rst_cnt", int'(cnt_rr), 0);
    step();
    chk("idle_we", int'(we_rr), 0);

    req = 3'b001;
    waddr_alu = 4'd5;
    step();
    chk("single_gnt", int'(gnt_rr), 1);
    chk("single_sel", int'(sel_rr), 0);
    chk("single_we", int'(we_rr), 1);
    chk("single_addr", int'(wa_rr), 5);
    req = 3'b000;
    step();
    chk("single_drop", int'(we_rr), 0);

    do_reset();
    req = 3'b111;
    exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rr_seq", int'(gnt_rr), int'(exp_seq[i]));
      chk("rr_sel_seq", int'(sel_rr), i % 3);
      chk("fx_seq", int'(gnt_fx), (i % 2 == 0) ? 1 : 2);
    end
    chk("rr_wait6", int'(cnt_rr), 6);

    do_reset();
    req = 3'b110;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("fx_110", int'(gnt_fx), (i % 2 == 0) ? 2 : 4);
    end

    do_reset();
    req = 3'b010;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("dbl_guard", int'(gnt_rr), (i % 2 == 0) ? 2 : 0);
    end

    do_reset();
    for (int i = 0; i < 3000; i++) begin
      req = 3'($urandom_range(0, 7));
      waddr_alu = 4'($urandom);
      waddr_mem = 4'($urandom);
      waddr_pc  = 4'($urandom);
      if ($urandom_range(0, 199) == 0) rst = 1'b1;
      else rst = 1'b0;
      step();
    end

    do_reset();
    req = 3'b111;
    for (int i = 0; i < 65540; i++) step();
    chk("sat_rr", int'(cnt_rr), 16'hFFFF);
    chk("sat_fx", int'(cnt_fx), 16'hFFFF);
    chk("pre_rst_we", int'(we_rr), 1);
    rst = 1'b1;
    step();
    chk("mid_rst_we", int'(we_rr), 0);
    chk("mid_rst_cnt", int'(cnt_rr), 0);
    chk("mid_rst_gnt", int'(gnt_rr), 0);
    rst = 1'b0;
    step();
    chk("rearb_gnt", int'(gnt_rr), 1);
    req = 3'b000;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_cmp, n_err);
    $finish;
  end

endmodule
